udp_rx_frame_fifo: RTL and testbench
====================================

Name: udp_rx_frame_fifo

Overview:
- Receive-side counterpart of the UDP transmit FIFO. Buffers UDP payload bytes from the UDP receiver and presents them to the application as whole, error-free frames.
- Frames are written speculatively and become visible to the reader only after a good last byte. Frames that end with an error or overflow the buffer are rolled back and counted as drops.
- Sits between the UDP/IP receive parser and the downstream payload consumer, all in one clock domain.

Parameters:
- ADDR_WIDTH, 7, log2 of buffer depth; DEPTH = 2**ADDR_WIDTH entries; legal range 4..10.
- DATA_WIDTH, 8, payload byte width.
- ALMOST_FULL_NUM, 120, almost_full asserts when speculative occupancy >= this value.
- ALMOST_EMPTY_NUM, 4, almost_empty asserts when committed occupancy <= this value.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  payload byte valid from the UDP receiver; there is no backpressure.
- in_data  in  DATA_WIDTH  payload byte.
- in_last  in  1  last byte of the frame, qualified by in_valid.
- in_error  in  1  frame bad (checksum/length); sampled only when in_valid & in_last.
- rd_en  in  1  pop request from the consumer.
- rd_data  out  DATA_WIDTH  popped byte, registered.
- rd_last  out  1  popped byte was the last byte of its frame.
- empty  out  1  no committed bytes unread.
- almost_empty  out  1  committed occupancy <= ALMOST_EMPTY_NUM.
- almost_full  out  1  speculative occupancy >= ALMOST_FULL_NUM.
- frame_drop  out  1  one-cycle pulse per dropped frame.
- drop_cnt  out  16  dropped-frame count, saturates at 0xFFFF.

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1) RAM holding {last, data}.
- Pointers are ADDR_WIDTH+1 bits wide and wrap modulo 2*DEPTH:
  - wr_ptr: speculative write pointer.
  - commit_ptr: end of the last committed frame.
  - rd_ptr: read pointer.
- Occupancy:
  - Speculative occupancy = wr_ptr - rd_ptr.
  - Committed occupancy = commit_ptr - rd_ptr.
  - full_int when speculative occupancy = DEPTH.
- Reset values:
  - All pointers 0; state IDLE.
  - rd_data 0, rd_last 0.
  - empty 1, almost_empty 1, almost_full 0.
  - frame_drop 0, drop_cnt 0.
  - Any frame in progress at reset is discarded. Bytes arriving after reset start a new frame.
- Write FSM (evaluated on in_valid only):
  - IDLE:
    - If full_int: go to DROP; if in_last, drop immediately and stay IDLE.
    - Otherwise: write the byte, wr_ptr+1.
    - If in_last & !in_error: commit_ptr <= wr_ptr+1, stay IDLE (single-byte frame).
    - If in_last & in_error: wr_ptr <= commit_ptr, drop.
    - Else go to FRAME.
  - FRAME:
    - Write as in IDLE; in_last commits or drops exactly as above, then go to IDLE.
    - If full_int on a valid byte: wr_ptr <= commit_ptr, go to DROP. If that byte has in_last, drop and go to IDLE.
  - DROP: ignore bytes; on in_last, drop and go to IDLE.
- "Drop" means all of the following in the same cycle:
  - frame_drop pulses 1 on the next cycle.
  - drop_cnt +1, saturating.
  - wr_ptr restored to commit_ptr.
- Read side:
  - A pop happens when rd_en & !empty: rd_ptr+1.
  - rd_data/rd_last update on the clock edge after rd_en, i.e. valid in the cycle after rd_en (1-cycle latency), and hold until the next pop.
  - rd_en while empty is ignored; outputs hold.
- Flag timing:
  - empty and almost_empty are registered, derived from next-state commit_ptr and rd_ptr.
  - empty deasserts the cycle after the committing last byte.
  - almost_full is registered from next-state wr_ptr and rd_ptr.
- Simultaneous events:
  - A pop and a commit in the same cycle both take effect.
  - A pop frees space in the same cycle for full_int evaluation of the next byte only, not the current one.
  - A rollback never moves wr_ptr below rd_ptr, because commit_ptr is always >= rd_ptr.
- Frames longer than DEPTH are always dropped. The buffer returns to its pre-frame state.

Test Plan:
- Reset, then frame of 5 bytes 0x11..0x15 with in_last on 0x15, in_error=0 -> empty falls the cycle after the last byte. Five pops return 0x11..0x15, rd_last=1 only with 0x15. empty=1 afterwards.
- Frame of 3 bytes ending with in_error=1 -> empty stays 1, frame_drop pulses once, drop_cnt=1. A following 2-byte good frame 0xA0,0xA1 reads back as exactly 0xA0,0xA1.
- DEPTH=128, no reads, 130-byte frame -> dropped at byte 129, drop_cnt=1, empty=1, speculative occupancy back to 0. A subsequent 128-byte frame commits and almost_full=1.
- Committed frame of 10 bytes present, rd_en held high while a 4-byte good frame arrives -> all 14 bytes read in order with no duplicates or gaps. almost_empty toggles correctly around 4.
- Assert rst mid-frame after 3 of 6 bytes, then a new 2-byte good frame -> outputs at reset values after rst; only the 2-byte frame is read; drop_cnt=0.
- Force drop_cnt to 0xFFFE, then drop 3 frames -> drop_cnt=0xFFFF and stays there; frame_drop pulses 3 times.

Source files
------------

// File: rtl/udp_rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// udp_rx_frame_fifo
//
// Receive-side frame FIFO. It buffers UDP payload bytes from the receive
// parser and releases them to the consumer only as whole, good frames. Bytes
// are written speculatively at wr_ptr. A good last byte moves commit_ptr up to
// wr_ptr, which makes the frame readable. A frame that ends with in_error, or
// that runs into a full buffer, is rolled back (wr_ptr <= commit_ptr) and
// counted as a drop.
//
// Handshake: the writer has no backpressure. A byte is taken on every cycle
// with in_valid=1. The reader pops when rd_en=1 and empty=0, and rd_data /
// rd_last are valid from the cycle after the pop until the next pop.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid        payload byte valid (no backpressure)
//   in_data         payload byte
//   in_last         last byte of the frame (qualified by in_valid)
//   in_error        frame bad, sampled with in_valid & in_last
//   rd_en           pop request
//   rd_data/rd_last popped byte and its end-of-frame marker (registered)
//   empty           no committed bytes unread
//   almost_empty    committed occupancy <= ALMOST_EMPTY_NUM
//   almost_full     speculative occupancy >= ALMOST_FULL_NUM
//   frame_drop      one-cycle pulse per dropped frame
//   drop_cnt        saturating dropped-frame counter
//
// The write FSM state is held in the named signal `state` (type state_t),
// so checkers can observe it.
// ---------------------------------------------------------------------------
module udp_rx_frame_fifo #(
    parameter int ADDR_WIDTH       = 7,
    parameter int DATA_WIDTH       = 8,
    parameter int ALMOST_FULL_NUM  = 120,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_error,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  frame_drop,
    output logic [15:0]           drop_cnt
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(ALMOST_FULL_NUM);
    localparam logic [PW-1:0] AE_P    = PW'(ALMOST_EMPTY_NUM);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0] wr_nxt, commit_nxt, rd_nxt;
    logic          full_int, we, drop, pop;

    // Fullness uses the current pointers only. A pop in this cycle frees
    // space for the next byte, not for the byte arriving now.
    assign full_int = ((wr_ptr - rd_ptr) == DEPTH_P);
    assign pop      = rd_en & ~empty;
    assign rd_nxt   = pop ? (rd_ptr + ONE_P) : rd_ptr;

    always_comb begin
        state_nxt  = state;
        wr_nxt     = wr_ptr;
        commit_nxt = commit_ptr;
        we         = 1'b0;
        drop       = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE, FRAME: begin
                    if (full_int) begin
                        // Roll back the partial frame. The rest of it is
                        // discarded in DROP unless this byte already ends it.
                        wr_nxt = commit_ptr;
                        if (in_last) begin
                            drop      = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DROP;
                        end
                    end else begin
                        we     = 1'b1;
                        wr_nxt = wr_ptr + ONE_P;
                        if (in_last) begin
                            state_nxt = IDLE;
                            if (in_error) begin
                                wr_nxt = commit_ptr;
                                drop   = 1'b1;
                            end else begin
                                commit_nxt = wr_ptr + ONE_P;
                            end
                        end else begin
                            state_nxt = FRAME;
                        end
                    end
                end
                DROP: begin
                    if (in_last) begin
                        drop      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Payload storage: {last, data}. Only committed entries are ever read,
    // and writes never land on unread entries, so no read/write collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            rd_ptr       <= '0;
            rd_data      <= '0;
            rd_last      <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            frame_drop   <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_nxt;
            commit_ptr <= commit_nxt;
            rd_ptr     <= rd_nxt;
            if (pop) begin
                {rd_last, rd_data} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            // Flags are computed from the next-state pointers so that they
            // line up with the pointers they describe.
            empty        <= (commit_nxt == rd_nxt);
            almost_empty <= ((commit_nxt - rd_nxt) <= AE_P);
            almost_full  <= ((wr_nxt - rd_nxt) >= AF_P);
            frame_drop   <= drop;
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// tb_udp_rx_frame_fifo
//
// Bench for udp_rx_frame_fifo with the default parameters (DEPTH = 128).
//
// The reference model is a queue of committed {last,data} bytes plus a queue
// holding the frame currently being received. From these it derives every
// output the design should show after each clock edge.
//
// Each scenario task drives stimulus one cycle at a time and compares all DUT
// outputs with the model, 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_udp_rx_frame_fifo;

    localparam int DEPTH = 128;
    localparam int AF    = 120;
    localparam int AE    = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_last, in_error, rd_en;
    logic [7:0] in_data;
    logic [7:0] rd_data;
    logic       rd_last, empty, almost_empty, almost_full, frame_drop;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    udp_rx_frame_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_error     (in_error),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .empty        (empty),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .frame_drop   (frame_drop),
        .drop_cnt     (drop_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cycles      = 0;

    // Observed outputs, packed in a fixed order for whole-cycle comparison:
    // rd_data[28:21] rd_last[20] empty[19] almost_empty[18]
    // almost_full[17] frame_drop[16] drop_cnt[15:0]
    logic [28:0] obs;
    assign obs = {rd_data, rd_last, empty, almost_empty, almost_full,
                  frame_drop, drop_cnt};

    // ---------------- reference model ----------------
    logic [8:0]  m_q[$];   // committed, unread bytes {last,data}
    logic [8:0]  m_pf[$];  // bytes of the frame being received
    bit          m_dropping;
    logic [15:0] m_cnt;
    logic        m_fd;
    logic [7:0]  m_rd_data;
    logic        m_rd_last;

    function automatic void model_reset();
        m_q.delete();
        m_pf.delete();
        m_dropping = 0;
        m_cnt      = '0;
        m_fd       = 1'b0;
        m_rd_data  = '0;
        m_rd_last  = 1'b0;
    endfunction

    function automatic void model_drop();
        m_fd = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] d,
                                       input logic l, input logic e,
                                       input logic r);
        int occ;
        int comm;
        logic [8:0] b;
        occ  = m_q.size() + m_pf.size();
        comm = m_q.size();
        m_fd = 1'b0;
        if (v) begin
            if (m_dropping) begin
                if (l) begin
                    model_drop();
                    m_dropping = 0;
                end
            end else if (occ == DEPTH) begin
                m_pf.delete();
                if (l) model_drop();
                else   m_dropping = 1;
            end else begin
                m_pf.push_back({l, d});
                if (l) begin
                    if (e) model_drop();
                    else foreach (m_pf[i]) m_q.push_back(m_pf[i]);
                    m_pf.delete();
                end
            end
        end
        // Only bytes committed before this edge can be popped now.
        if (r && comm > 0) begin
            b         = m_q.pop_front();
            m_rd_data = b[7:0];
            m_rd_last = b[8];
        end
    endfunction

    function automatic logic [28:0] exp_vec();
        return {m_rd_data, m_rd_last, (m_q.size() == 0), (m_q.size() <= AE),
                ((m_q.size() + m_pf.size()) >= AF), m_fd, m_cnt};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic v, input logic [7:0] d, input logic l,
                       input logic e, input logic r);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        in_error = e;
        rd_en    = r;
        @(posedge clk);
        model_step(v, d, l, e, r);
        #1;
        cycles++;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_error = 1'b0;
        rd_en    = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        vectors++;
        if (obs !== 29'h00_0C_0000 || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_basic_frame();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'h11 + 8'(i), (i == 4), 1'b0, 1'b0);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL basic_write byte %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL basic_read pop %0d: got %h expected %h", i, obs, exp_vec());
            end
            if (i < 5) begin
                vectors++;
                if (rd_data !== 8'h11 + 8'(i) || rd_last !== (i == 4)) begin
                    miscompares++;
                    $display("FAIL basic_read_value pop %0d: got %h/%b expected %h/%b",
                             i, rd_data, rd_last, 8'h11 + 8'(i), (i == 4));
                end
            end
        end
    endtask

    task automatic test_error_frame();
        logic [7:0] pat [5];
        logic       lst [5];
        logic       err [5];
        pat = '{8'h31, 8'h32, 8'h33, 8'hA0, 8'hA1};
        lst = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        err = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, pat[i], lst[i], err[i], 1'b0);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL error_frame byte %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL error_frame_read pop %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_overflow();
        logic [8:0] n;
        for (int i = 0; i < 130; i++) begin
            cyc(1'b1, 8'($urandom), (i == 129), 1'b0, 1'b0);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL overflow_frame byte %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        for (int i = 0; i < 128; i++) begin
            cyc(1'b1, 8'($urandom), (i == 127), 1'b0, 1'b0);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL full_frame byte %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        vectors++;
        if (almost_full !== 1'b1 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL full_frame_flags: got af=%b empty=%b expected af=1 empty=0",
                     almost_full, empty);
        end
        n = 0;
        while (m_q.size() > 0 && n < 200) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            n++;
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL full_drain pop %0d: got %h expected %h", n, obs, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'h40 + 8'(i), (i == 9), 1'b0, 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // Read continuously while a 4-byte frame streams in.
        for (int i = 0; i < 18; i++) begin
            if (i < 4) cyc(1'b1, 8'h60 + 8'(i), (i == 3), 1'b0, 1'b1);
            else       cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b0);
        do_reset();
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_mid_frame_state: got %h expected %h", obs, exp_vec());
        end
        cyc(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hB1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_mid_frame_read %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_saturate();
        int pulses;
        pulses = 0;
        force dut.drop_cnt = 16'hFFFE;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        release dut.drop_cnt;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) cyc(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
            else       cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (frame_drop === 1'b1) pulses++;
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL saturate cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        vectors++;
        if (drop_cnt !== 16'hFFFF || pulses != 3) begin
            miscompares++;
            $display("FAIL saturate_final: got cnt=%h pulses=%0d expected cnt=ffff pulses=3",
                     drop_cnt, pulses);
        end
    endtask

    task automatic test_random(input int n_cycles, input int rd_pct);
        int         rem;
        logic       v, l, e, r;
        logic [7:0] d;
        rem = 0;
        for (int c = 0; c < n_cycles; c++) begin
            if (rem == 0) begin
                case ($urandom_range(0, 9))
                    0:       rem = $urandom_range(125, 140);
                    1:       rem = 1;
                    default: rem = $urandom_range(2, 24);
                endcase
            end
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            l = v && (rem == 1);
            e = l && ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 99) < rd_pct);
            if (v) rem--;
            cyc(v, d, l, e, r);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %h expected %h", c, obs, exp_vec());
            end
        end
        // Finish the open frame and drain.
        while (rem > 0) begin
            cyc(1'b1, 8'($urandom), (rem == 1), 1'b0, 1'b1);
            rem--;
        end
        for (int k = 0; k < 300 && m_q.size() > 0; k++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        vectors++;
        if (obs !== exp_vec() || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL random_drain: got %h expected %h", obs, exp_vec());
        end
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycles);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_error_frame();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        test_saturate();
        test_random(2500, 55);
        test_random(1500, 15);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
